// File: rtl/kbd_fifo_68k_if.sv
// rtl/kbd_fifo_68k_if.sv - PS/2 event input and 68k-style register bus for the keyboard FIFO
interface kbd_fifo_68k_if;
  logic [10:0] ps2_key;
  logic        cpu_sel;
  logic [1:0]  cpu_a;
  logic        cpu_rw;
  logic        cpu_as_n;
  logic        cpu_lds_n;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        dtack_n;
  logic        irq;

  modport master (
    output ps2_key, cpu_sel, cpu_a, cpu_rw, cpu_as_n, cpu_lds_n, cpu_din,
    input  cpu_dout, dtack_n, irq
  );

  modport slave (
    input  ps2_key, cpu_sel, cpu_a, cpu_rw, cpu_as_n, cpu_lds_n, cpu_din,
    output cpu_dout, dtack_n, irq
  );
endinterface

// File: rtl/kbd_fifo_68k.sv
// rtl/kbd_fifo_68k.sv - PS/2 key event FIFO exposed as a 4-register 68k peripheral with DTACK and IRQ
module kbd_fifo_68k #(
  parameter int C_DEPTH_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  kbd_fifo_68k_if.slave bus
);
  localparam int DEPTH = 1 << C_DEPTH_BITS;
  localparam logic [C_DEPTH_BITS:0] DEPTH_CNT = (C_DEPTH_BITS + 1)'(DEPTH);

  logic [9:0]              mem_q [DEPTH];
  logic [C_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [C_DEPTH_BITS:0]   count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    irq_en_q, irq_en_d;
  logic                    irq_q;
  logic                    dtack_n_q;
  logic                    pend_pop_q, pend_pop_d;
  logic                    prev_tog_q, primed_q;

  logic acc, empty, full, ev, ctrl_wr, flush, clr_ovf, pop_now, pop, push, drop;
  logic unused_din;

  assign unused_din = ^bus.cpu_din[15:3];

  assign acc     = bus.cpu_sel & ~bus.cpu_as_n;
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign ev      = primed_q & (bus.ps2_key[10] != prev_tog_q);
  // dtack_n_q is still high on the first clock of an access, so a held write strobes once
  assign ctrl_wr = acc & dtack_n_q & ~bus.cpu_rw & (bus.cpu_a == 2'd2) & ~bus.cpu_lds_n;
  assign flush   = ctrl_wr & bus.cpu_din[1];
  assign clr_ovf = ctrl_wr & bus.cpu_din[2];
  assign pop_now = pend_pop_q & bus.cpu_as_n;
  assign pop     = pop_now & ~empty;
  // A pop in the same clock frees the slot that a push into a full FIFO needs
  assign push    = ev & ~flush & (~full | pop);
  assign drop    = ev & ~flush & full & ~pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pend_pop_d = pend_pop_q;
    ovf_d      = ovf_q;
    irq_en_d   = irq_en_q;
    if (ctrl_wr) irq_en_d = bus.cpu_din[0];
    if (drop) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pend_pop_d = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (acc && bus.cpu_rw && bus.cpu_a == 2'd0) pend_pop_d = 1'b1;
      else if (pop_now) pend_pop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      dtack_n_q  <= 1'b1;
      pend_pop_q <= 1'b0;
      prev_tog_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_q & ~empty;
      dtack_n_q  <= ~acc;
      pend_pop_q <= pend_pop_d;
      prev_tog_q <= bus.ps2_key[10];
      primed_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.ps2_key[9:0];
  end

  always_comb begin
    bus.cpu_dout = '0;
    if (bus.cpu_sel) begin
      case (bus.cpu_a)
        2'd0: if (!empty) bus.cpu_dout = {6'b100000, mem_q[rd_ptr_q]};
        2'd1: begin
          bus.cpu_dout[15]             = ovf_q;
          bus.cpu_dout[14]             = full;
          bus.cpu_dout[13]             = empty;
          bus.cpu_dout[C_DEPTH_BITS:0] = count_q;
        end
        2'd2: bus.cpu_dout[0] = irq_en_q;
        default: bus.cpu_dout = '0;
      endcase
    end
  end

  assign bus.dtack_n = dtack_n_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_kbd_fifo_68k.sv
// tb/tb_kbd_fifo_68k.sv - randomized self-checking bench for kbd_fifo_68k against a queue model
module tb_kbd_fifo_68k;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  kbd_fifo_68k_if bus ();
  kbd_fifo_68k #(.C_DEPTH_BITS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_irq_en = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, wanted 0x%04h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {m_ovf, (mq.size() == 16), (mq.size() == 0), 5'b0, 8'(mq.size())};
  endfunction

  function automatic logic [15:0] m_head();
    return (mq.size() != 0) ? {6'b100000, mq[0]} : 16'h0000;
  endfunction

  function automatic void m_push(input logic [9:0] v);
    if (mq.size() < 16) mq.push_back(v);
    else m_ovf = 1'b1;
  endfunction

  task automatic toggle(input logic [9:0] v);
    bus.ps2_key = {~bus.ps2_key[10], v};
  endtask

  task automatic push_ev(input logic [9:0] v);
    @(negedge clk);
    toggle(v);
    m_push(v);
  endtask

  // One complete bus cycle; optional key event on the first or the last clock of it
  task automatic bus_cycle(input logic [1:0] a, input logic rw, input logic [15:0] din,
                           input logic lds_n, input int hold, input bit ev_start,
                           input bit ev_end, input logic [9:0] ev_v, output logic [15:0] rd);
    logic [15:0] exp_rd;
    @(negedge clk);
    chk("dtack_idle", {15'b0, bus.dtack_n}, 16'h0001);
    bus.cpu_sel = 1'b1; bus.cpu_a = a; bus.cpu_rw = rw; bus.cpu_din = din;
    bus.cpu_lds_n = lds_n; bus.cpu_as_n = 1'b0;
    if (ev_start) toggle(ev_v);
    case (a)
      2'd0: exp_rd = m_head();
      2'd1: exp_rd = m_status();
      2'd2: exp_rd = {15'b0, m_irq_en};
      default: exp_rd = 16'h0000;
    endcase
    if (!rw && a == 2'd2 && !lds_n) begin
      m_irq_en = din[0];
      if (din[2]) m_ovf = 1'b0;
      if (din[1]) mq.delete();
      else if (ev_start) m_push(ev_v);
    end else if (ev_start) m_push(ev_v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("dtack_low", {15'b0, bus.dtack_n}, 16'h0000);
      if (rw) chk($sformatf("rd_reg%0d", a), bus.cpu_dout, exp_rd);
    end
    rd = bus.cpu_dout;
    bus.cpu_as_n = 1'b1;
    if (ev_end) toggle(ev_v);
    if (rw && a == 2'd0 && mq.size() != 0) void'(mq.pop_front());
    if (ev_end) m_push(ev_v);
    @(negedge clk);
    chk("dtack_release", {15'b0, bus.dtack_n}, 16'h0001);
    bus.cpu_sel = 1'b0; bus.cpu_lds_n = 1'b1; bus.cpu_rw = 1'b1;
  endtask

  task automatic rd_reg(input logic [1:0] a, input int hold, output logic [15:0] rd);
    bus_cycle(a, 1'b1, 16'h0, 1'b0, hold, 1'b0, 1'b0, 10'h0, rd);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] din);
    logic [15:0] rd;
    bus_cycle(a, 1'b0, din, 1'b0, 2, 1'b0, 1'b0, 10'h0, rd);
  endtask

  task automatic chk_irq();
    repeat (2) @(negedge clk);
    chk("irq_level", {15'b0, bus.irq}, {15'b0, (m_irq_en && mq.size() != 0)});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    int op;
    bus.ps2_key = 11'h400; bus.cpu_sel = 1'b0; bus.cpu_a = 2'd0; bus.cpu_rw = 1'b1;
    bus.cpu_as_n = 1'b1; bus.cpu_lds_n = 1'b1; bus.cpu_din = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_dtack", {15'b0, bus.dtack_n}, 16'h0001);
    chk("rst_irq", {15'b0, bus.irq}, 16'h0000);
    chk("idle_dout", bus.cpu_dout, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    rd_reg(2'd1, 1, r); chk("status_after_reset", r, 16'h2000);

    push_ev(10'h21C); push_ev(10'h232); push_ev(10'h221);
    rd_reg(2'd1, 1, r); chk("status_three", r, 16'h0003);
    rd_reg(2'd0, 2, r); chk("data0", r, 16'h821C);
    rd_reg(2'd0, 1, r); chk("data1", r, 16'h8232);
    rd_reg(2'd0, 3, r); chk("data2", r, 16'h8221);
    rd_reg(2'd0, 1, r); chk("data_empty", r, 16'h0000);
    rd_reg(2'd1, 1, r); chk("status_drained", r, 16'h2000);

    for (int i = 0; i < 17; i++) push_ev(10'($urandom));
    rd_reg(2'd1, 1, r); chk("status_overflow", r, 16'hC010);
    wr_reg(2'd2, 16'h0004);
    rd_reg(2'd1, 1, r); chk("status_ovf_cleared", r, 16'h4010);
    for (int i = 0; i < 16; i++) rd_reg(2'd0, 1, r);
    rd_reg(2'd1, 1, r); chk("status_after_16", r, 16'h2000);

    wr_reg(2'd2, 16'h0001);
    rd_reg(2'd2, 1, r); chk("ctrl_readback", r, 16'h0001);
    push_ev(10'h05A);
    @(negedge clk); chk("irq_lag", {15'b0, bus.irq}, 16'h0000);
    @(negedge clk); chk("irq_set", {15'b0, bus.irq}, 16'h0001);
    rd_reg(2'd0, 2, r); chk("irq_data", r, 16'h805A);
    chk("irq_hold", {15'b0, bus.irq}, 16'h0001);
    @(negedge clk); chk("irq_clear", {15'b0, bus.irq}, 16'h0000);

    bus_cycle(2'd2, 1'b0, 16'h0006, 1'b1, 2, 1'b0, 1'b0, 10'h0, r);
    rd_reg(2'd2, 1, r); chk("ctrl_lds_ignored", r, 16'h0001);

    for (int i = 0; i < 16; i++) push_ev(10'($urandom));
    bus_cycle(2'd0, 1'b1, 16'h0, 1'b0, 2, 1'b0, 1'b1, 10'h3E7, r);
    rd_reg(2'd1, 1, r); chk("status_pop_push_full", r, 16'h4010);

    rd_reg(2'd0, 10, r);
    rd_reg(2'd1, 1, r); chk("status_long_cycle", r, 16'h000F);
    bus_cycle(2'd2, 1'b0, 16'h0002, 1'b0, 2, 1'b1, 1'b0, 10'h111, r);
    rd_reg(2'd1, 1, r); chk("status_flush", r, 16'h2000);

    push_ev(10'h0AA); push_ev(10'h0BB);
    @(negedge clk);
    bus.cpu_sel = 1'b1; bus.cpu_a = 2'd0; bus.cpu_rw = 1'b1; bus.cpu_as_n = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; bus.cpu_sel = 1'b0; bus.cpu_as_n = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_irq_en = 1'b0;
    @(negedge clk);
    chk("midrst_dtack", {15'b0, bus.dtack_n}, 16'h0001);
    reset = 1'b0;
    @(negedge clk);
    rd_reg(2'd1, 1, r); chk("status_midrst", r, 16'h2000);

    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: push_ev(10'($urandom));
        4, 5: rd_reg(2'd0, $urandom_range(1, 3), r);
        6: begin rd_reg(2'd1, 1, r); chk_irq(); end
        7: bus_cycle(2'd2, 1'b0,
                     {13'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom)},
                     1'b0, $urandom_range(1, 3), 1'($urandom), 1'b0, 10'($urandom), r);
        8: bus_cycle(2'd0, 1'b1, 16'h0, 1'b0, $urandom_range(1, 4), 1'b0, 1'($urandom),
                     10'($urandom), r);
        default: bus_cycle(2'($urandom_range(1, 3)), 1'($urandom), 16'($urandom), 1'b0,
                           1, 1'b0, 1'b0, 10'h0, r);
      endcase
    end
    rd_reg(2'd1, 1, r); chk("status_final", r, m_status());
    chk_irq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
